mii_frame_dump_ctrl: RTL

Controller that sequences the dump of a captured MII receive frame out over the UART.
- When the receive path flags a complete frame in the frame buffer, the block reads the buffer byte by byte.
- Each byte is converted to uppercase hex ASCII and paced into the UART transmitter through its dv/active/done handshake.
- When the dump is finished, the block returns the buffer to the receive path.
- It sits between the MII receive buffer and the UART TX in the MIIulator top level.

---
 rtl/mii_frame_dump_ctrl.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/mii_frame_dump_ctrl.sv
// mii_frame_dump_ctrl: reads a captured MII receive frame out of the frame
// buffer and sends it to the UART as uppercase hex ASCII. Bytes are separated
// by spaces, and a CR LF ends every LINE_BYTES bytes and the frame itself.
// Optional feature macro: DUMP_HEADER_EN prefixes each dump with the clamped
// length as four hex digits followed by ':'.
module mii_frame_dump_ctrl #(
    parameter int ADDR_W     = 11,
    parameter int MAX_LEN    = 1536,
    parameter int LINE_BYTES = 16
) (
    input  logic              clk,
    input  logic              SW0,
    input  logic              frm_valid,
    input  logic [ADDR_W-1:0] frm_len,
    output logic              frm_ack,
    output logic              buf_rd,
    output logic [ADDR_W-1:0] buf_addr,
    input  logic [7:0]        buf_data,
    output logic              tx_dv,
    output logic [7:0]        tx_byte,
    input  logic              tx_active,
    input  logic              tx_done,
    output logic              busy
);
    // One extra bit lets the byte counter reach MAX_LEN without wrapping.
    localparam int CNT_W  = ADDR_W + 1;
    localparam int LINE_W = $clog2(LINE_BYTES + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_WAIT, S_HI, S_LO, S_SP, S_CR, S_LF, S_ACK
`ifdef DUMP_HEADER_EN
        , S_HDR
`endif
    } state_t;

    state_t              state_q, state_d;
    logic                issued_q, issued_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
    logic [LINE_W-1:0]   line_cnt_q, line_cnt_d;
    logic [7:0]          data_q, data_d;
`ifdef DUMP_HEADER_EN
    logic [2:0]          hdr_cnt_q, hdr_cnt_d;
    logic [15:0]         len16;
`endif

    logic [CNT_W-1:0]    frm_len_ext, len_clamped, byte_nxt;
    logic                is_char, char_done;
    logic [7:0]          char_val;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    assign frm_len_ext = {1'b0, frm_len};
    assign len_clamped = (frm_len_ext > CNT_W'(MAX_LEN)) ? CNT_W'(MAX_LEN) : frm_len_ext;
    assign byte_nxt    = byte_cnt_q + 1'b1;
    assign buf_addr    = byte_cnt_q[ADDR_W-1:0];
    assign busy        = (state_q != S_IDLE);
`ifdef DUMP_HEADER_EN
    assign len16       = 16'(len_q);
`endif

    // Character to present for the current character state.
    always_comb begin
        is_char  = 1'b1;
        char_val = 8'h00;
        case (state_q)
            S_HI: char_val = hex_ascii(data_q[7:4]);
            S_LO: char_val = hex_ascii(data_q[3:0]);
            S_SP: char_val = 8'h20;
            S_CR: char_val = 8'h0D;
            S_LF: char_val = 8'h0A;
`ifdef DUMP_HEADER_EN
            S_HDR: begin
                case (hdr_cnt_q)
                    3'd0:    char_val = hex_ascii(len16[15:12]);
                    3'd1:    char_val = hex_ascii(len16[11:8]);
                    3'd2:    char_val = hex_ascii(len16[7:4]);
                    3'd3:    char_val = hex_ascii(len16[3:0]);
                    default: char_val = 8'h3A;
                endcase
            end
`endif
            default: is_char = 1'b0;
        endcase
    end

    // A character is finished only by a tx_done that follows our own tx_dv.
    assign char_done = is_char && issued_q && tx_done;

    // Next-state and output decode, including the shared UART handshake.
    always_comb begin
        state_d    = state_q;
        issued_d   = issued_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        line_cnt_d = line_cnt_q;
        data_d     = data_q;
`ifdef DUMP_HEADER_EN
        hdr_cnt_d  = hdr_cnt_q;
`endif
        frm_ack    = 1'b0;
        buf_rd     = 1'b0;
        tx_dv      = 1'b0;
        tx_byte    = 8'h00;

        if (is_char) begin
            tx_byte = char_val;
            if (!issued_q && !tx_active) begin
                tx_dv    = 1'b1;
                issued_d = 1'b1;
            end
        end
        if (char_done) begin
            issued_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (frm_valid) begin
                    len_d      = len_clamped;
                    byte_cnt_d = '0;
                    line_cnt_d = '0;
                    issued_d   = 1'b0;
`ifdef DUMP_HEADER_EN
                    hdr_cnt_d  = 3'd0;
                    state_d    = S_HDR;
`else
                    state_d    = (len_clamped == '0) ? S_CR : S_FETCH;
`endif
                end
            end
`ifdef DUMP_HEADER_EN
            S_HDR: begin
                if (char_done) begin
                    if (hdr_cnt_q == 3'd4) begin
                        state_d = (len_q == '0) ? S_CR : S_FETCH;
                    end else begin
                        hdr_cnt_d = hdr_cnt_q + 3'd1;
                    end
                end
            end
`endif
            S_FETCH: begin
                buf_rd  = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                data_d  = buf_data;
                state_d = S_HI;
            end
            S_HI: if (char_done) state_d = S_LO;
            S_LO: begin
                if (char_done) begin
                    byte_cnt_d = byte_nxt;
                    if (byte_nxt == len_q) begin
                        state_d = S_CR;
                    end else if (line_cnt_q == LINE_W'(LINE_BYTES - 1)) begin
                        line_cnt_d = '0;
                        state_d    = S_CR;
                    end else begin
                        line_cnt_d = line_cnt_q + 1'b1;
                        state_d    = S_SP;
                    end
                end
            end
            S_SP: if (char_done) state_d = S_FETCH;
            S_CR: if (char_done) state_d = S_LF;
            S_LF: if (char_done) state_d = (byte_cnt_q == len_q) ? S_ACK : S_FETCH;
            S_ACK: begin
                frm_ack = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state and counters; reset aborts any dump in progress.
    always_ff @(posedge clk) begin
        if (SW0) begin
            state_q    <= S_IDLE;
            issued_q   <= 1'b0;
            len_q      <= '0;
            byte_cnt_q <= '0;
            line_cnt_q <= '0;
`ifdef DUMP_HEADER_EN
            hdr_cnt_q  <= 3'd0;
`endif
        end else begin
            state_q    <= state_d;
            issued_q   <= issued_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            line_cnt_q <= line_cnt_d;
`ifdef DUMP_HEADER_EN
            hdr_cnt_q  <= hdr_cnt_d;
`endif
        end
    end

    // Captured buffer byte; pure data, only meaningful after WAIT.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

endmodule
